// File: rtl/input_manager.sv
// input_manager: turns debounced key levels into one-cycle game command pulses,
// one-shot for rotate/drop and auto-shift (DAS) repeat for left/right/down.
module input_manager #(
   parameter int DAS_DELAY = 16,
   parameter int DAS_SPEED = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_game,
   input  logic raw_left,
   input  logic raw_right,
   input  logic raw_down,
   input  logic raw_rotate,
   input  logic raw_drop,
   output logic cmd_left,
   output logic cmd_right,
   output logic cmd_down,
   output logic cmd_rotate,
   output logic cmd_drop
);
   localparam int TW_MIN = $clog2(DAS_DELAY + DAS_SPEED + 2);
   localparam int TW = TW_MIN > 5 ? TW_MIN : 5;
   localparam logic [TW-1:0] LAST = TW'(DAS_DELAY + DAS_SPEED + 1);
   localparam logic [TW-1:0] RELOAD = TW'(DAS_DELAY + 2);
   logic prev_left, prev_right, prev_down, prev_rotate, prev_drop;
   logic [TW-1:0] timer_left, timer_right, timer_down;
   // returns {pulse, next timer}; reload keeps the repeat period at DAS_SPEED ticks
   function automatic logic [TW:0] das_step(input logic raw, input logic prev,
                                            input logic tick, input logic [TW-1:0] t);
      return !raw ? '0 :
             !prev ? {1'b1, {TW{1'b0}}} :
             !tick ? {1'b0, t} :
             t == LAST ? {1'b1, RELOAD} : {1'b0, t + TW'(1)};
   endfunction
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         {prev_left, prev_right, prev_down, prev_rotate, prev_drop} <= '0;
         {cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop} <= '0;
         timer_left <= '0;
         timer_right <= '0;
         timer_down <= '0;
      end else begin
         {prev_left, prev_right, prev_down, prev_rotate, prev_drop} <=
            {raw_left, raw_right, raw_down, raw_rotate, raw_drop};
         {cmd_left, timer_left} <= das_step(raw_left, prev_left, tick_game, timer_left);
         {cmd_right, timer_right} <= das_step(raw_right, prev_right, tick_game, timer_right);
         {cmd_down, timer_down} <= das_step(raw_down, prev_down, tick_game, timer_down);
         cmd_rotate <= raw_rotate & ~prev_rotate;
         cmd_drop <= raw_drop & ~prev_drop;
      end
endmodule

// File: tb/tb_input_manager.sv
// tb_input_manager: table vectors plus schedule-model scoreboard for input_manager.
module tb_input_manager;
   localparam int FIRST_REP = 22;
   localparam int SPEED = 4;
   logic clk = 1'b0, rst = 1'b0, tick_game = 1'b0;
   logic [4:0] raw = '0;
   logic cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop;
   int checks = 0, failures = 0;
   logic [4:0] exp_q[$];
   int mn[5];
   logic [4:0] mprev;
   typedef struct {
      logic [4:0] raw;
      logic       tick;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[18];

   always #5 clk = ~clk;

   input_manager dut (
      .clk(clk), .rst(rst), .tick_game(tick_game),
      .raw_left(raw[4]), .raw_right(raw[3]), .raw_down(raw[2]),
      .raw_rotate(raw[1]), .raw_drop(raw[0]),
      .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_down(cmd_down),
      .cmd_rotate(cmd_rotate), .cmd_drop(cmd_drop)
   );

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      mprev = '0;
      foreach (mn[i]) mn[i] = 0;
   endtask

   // Model counts ticks since the press; repeats land on tick 22, 26, 30, ...
   task automatic cycle(input string tag, input logic [4:0] r, input logic t,
                        input logic use_exp = 1'b0, input logic [4:0] e = '0);
      logic [4:0] m;
      logic [4:0] ex;
      @(negedge clk);
      raw = r;
      tick_game = t;
      for (int i = 0; i < 5; i++) begin
         m[i] = 1'b0;
         if (!r[i]) mn[i] = 0;
         else if (!mprev[i]) begin
            mn[i] = 0;
            m[i] = 1'b1;
         end else if (i >= 2 && t) begin
            mn[i]++;
            m[i] = mn[i] >= FIRST_REP && (mn[i] - FIRST_REP) % SPEED == 0;
         end
      end
      mprev = r;
      exp_q.push_back(use_exp ? e : m);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      check(tag, {cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop}, ex);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{5'b00010, 1'b0, 5'b00010};
      for (int i = 1; i <= 10; i++) tbl[i] = '{5'b00010, 1'(i % 2), 5'b00000};
      tbl[11] = '{5'b00000, 1'b0, 5'b00000};
      tbl[12] = '{5'b00010, 1'b1, 5'b00010};
      tbl[13] = '{5'b00011, 1'b0, 5'b00001};
      tbl[14] = '{5'b00011, 1'b1, 5'b00000};
      tbl[15] = '{5'b00000, 1'b0, 5'b00000};
      tbl[16] = '{5'b00001, 1'b0, 5'b00001};
      tbl[17] = '{5'b00000, 1'b0, 5'b00000};
      model_reset();
      raw = '1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmds", {cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop}, 0);
      check("reset_timer", int'(dut.timer_left), 0);
      rst = 1'b1;
      cycle("release_press", 5'b11111, 1'b0);
      repeat (3) cycle("release_hold", 5'b11111, 1'b0);
      cycle("release_idle", 5'b00000, 1'b0);
      foreach (tbl[i]) cycle($sformatf("tbl_%0d", i), tbl[i].raw, tbl[i].tick, 1'b1, tbl[i].exp);
      cycle("left_press", 5'b10000, 1'b0);
      for (int n = 1; n <= 30; n++) begin
         cycle($sformatf("left_tick%0d", n), 5'b10000, 1'b1);
         if (n == 21) check("left_timer21", int'(dut.timer_left), 21);
         if (n == 22) check("left_timer22", int'(dut.timer_left), 18);
         cycle("left_gap", 5'b10000, 1'b0);
      end
      cycle("left_rel", 5'b00000, 1'b0);
      cycle("mid_press", 5'b10000, 1'b0);
      for (int n = 1; n <= 10; n++) begin
         cycle("mid_tick", 5'b10000, 1'b1);
         cycle("mid_gap", 5'b10000, 1'b0);
      end
      cycle("mid_rel", 5'b00000, 1'b0);
      cycle("mid_repress", 5'b10000, 1'b0);
      for (int n = 1; n <= 24; n++) begin
         cycle($sformatf("mid_tick%0d", n), 5'b10000, 1'b1);
         cycle("mid_gap2", 5'b10000, 1'b0);
      end
      cycle("mid_rel2", 5'b00000, 1'b0);
      cycle("sim_press", 5'b10101, 1'b1);
      for (int n = 1; n <= 24; n++) begin
         cycle($sformatf("sim_tick%0d", n), 5'b10101, 1'b1);
         cycle("sim_gap", 5'b10101, 1'b0);
      end
      cycle("sim_rel", 5'b00000, 1'b0);
      cycle("right_press", 5'b01000, 1'b1);
      for (int n = 1; n <= 30; n++) cycle($sformatf("right_held_tick%0d", n), 5'b01000, 1'b1);
      cycle("right_rel", 5'b00000, 1'b0);
      cycle("async_press", 5'b10000, 1'b0);
      for (int n = 1; n <= 15; n++) begin
         cycle("async_tick", 5'b10000, 1'b1);
         cycle("async_gap", 5'b10000, 1'b0);
      end
      check("async_timer_pre", int'(dut.timer_left), 15);
      cycle("async_rot", 5'b10010, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("async_cmds", {cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop}, 0);
      check("async_timer", int'(dut.timer_left), 0);
      raw = '0;
      tick_game = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle("post_idle", 5'b00000, 1'b0);
      cycle("post_press", 5'b00100, 1'b0);
      cycle("post_rel", 5'b00000, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/input_manager.md
Name: input_manager

Overview:
- Converts five debounced, synchronous key levels (left, right, down, rotate, drop) into one-cycle game command pulses for the Tetris game FSM.
- Rotate and drop are one-shot: exactly one pulse per press.
- Left, right and down use auto-shift (DAS): one immediate pulse on press, then repeat pulses paced by the game frame tick while the key stays held.

Parameters:
- DAS_DELAY, 16, frame ticks of hold before auto-repeat arms.
- DAS_SPEED, 4, frame ticks between successive auto-repeat pulses.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  asynchronous, active-low reset
- tick_game  input  1  one-clk pulse per game frame
- raw_left  input  1  left key level, synchronous to clk
- raw_right  input  1  right key level
- raw_down  input  1  soft-drop key level
- raw_rotate  input  1  rotate key level
- raw_drop  input  1  hard-drop key level
- cmd_left  output  1  move-left command pulse
- cmd_right  output  1  move-right command pulse
- cmd_down  output  1  move-down command pulse
- cmd_rotate  output  1  rotate command pulse
- cmd_drop  output  1  hard-drop command pulse

Behaviour:
- Reset (rst=0, async):
  - all cmd_* = 0.
  - previous-level registers = 0.
  - DAS timers = 0.
  - A key held through reset release therefore yields a press pulse on the first clk edge after release.
- Edge detect per key: register prev_x <= raw_x every clk; press = raw_x & ~prev_x.
- All cmd_* are registered. A press sampled at clk edge E drives cmd high from E until edge E+1, exactly one cycle, regardless of tick_game.
- Rotate/drop: pulse only on press. Holding produces nothing further. A new pulse requires release (≥1 cycle low) and re-press.
- DAS channels (left, right, down): each has an independent internal timer (timer_left, timer_right, timer_down).
  - Width ≥ 5 bits; must hold DAS_DELAY+DAS_SPEED+1.
  - Press cycle: emit immediate pulse; timer <= 0. A tick_game in the same cycle is ignored for that channel.
  - Held and tick_game=1, timer != DAS_DELAY+DAS_SPEED+1: timer <= timer+1; no pulse.
  - Held and tick_game=1, timer == DAS_DELAY+DAS_SPEED+1 (21): emit repeat pulse; timer <= DAS_DELAY+2 (18).
  - Resulting schedule, with ticks numbered N=1.. after the press cycle: no pulse for N=1..21; repeat pulses at N=22, 26, 30, … (every DAS_SPEED ticks).
  - Repeat pulse visible in the cycle after the tick is sampled; one cycle wide.
  - Key low: timer <= 0; no pulses.
  - Release and re-press restarts the full DAS sequence.
- Channels are fully independent. Simultaneous keys (e.g. left+right) each produce their own pulses in the same cycle. No priority or masking.
- tick_game is assumed one cycle wide. If held high longer, each high cycle counts as a tick.
- Outputs never exceed one consecutive high cycle per event.
- Exception: back-to-back events on consecutive clocks (press then immediate repeat) cannot occur, because timer starts at 0.

Test Plan:
- Reset: hold rst=0 with all raw_* = 1 → all cmd_* = 0. Release rst → each cmd_* pulses once on the first edge, then stays 0 while held.
- Rotate one-shot: raw_rotate 0→1 → cmd_rotate = 1 after the next edge, 0 after the following edge. Hold 10 cycles → stays 0. Release, re-press → pulses again.
- Left DAS: press raw_left → immediate pulse. Apply 21 tick_game pulses (1 tick per 2 clks) → cmd_left stays 0 and timer_left = 21. Tick 22 → cmd_left = 1 for one cycle, timer_left = 18. Ticks 23–25 silent, tick 26 pulses.
- Release mid-DAS: hold left for 10 ticks, release, re-press → immediate pulse; next repeat only at tick 22 after the re-press.
- Simultaneous channels: press left and down together, tick 22 times → both pulse on press and both repeat on tick 22. Drop held throughout → single cmd_drop pulse.
- Async reset mid-operation: assert rst=0 between clock edges during DAS (timer ≈ 15) → outputs and timers clear immediately without waiting for clk.
